// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute and write-back back end of the 8-bit pipeline.
// EX operand A is forwarded from WB, the result is registered into EX/WB,
// then committed to an 8x8 register file with an ID-side bypassed read port.
module ex_wb_stage (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] EX_ALUop,
   input  logic       EX_RegWrite,
   input  logic       EX_LoadImmediate,
   input  logic [7:0] EX_RegData1,
   input  logic [2:0] EX_readReg1,
   input  logic [2:0] EX_writeReg,
   input  logic [7:0] EX_ImmediateData,
   input  logic [7:0] EX_instr,
   input  logic [2:0] ID_readReg1,
   output logic [7:0] ID_RegData1,
   output logic       WB_RegWrite,
   output logic [2:0] WB_writeReg,
   output logic [7:0] WB_result,
   output logic [7:0] WB_instr,
   output logic       WB_zero,
   output logic       WB_carry
);

   typedef enum logic [3:0] {
      OP_PASS = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_SUB  = 4'b0010,
      OP_AND  = 4'b0011,
      OP_OR   = 4'b0100,
      OP_XOR  = 4'b0101,
      OP_NOT  = 4'b0110,
      OP_SHL  = 4'b0111,
      OP_SHR  = 4'b1000,
      OP_INC  = 4'b1001,
      OP_DEC  = 4'b1010
   } alu_op_e;

   logic [7:0] rf [8];
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [2:0] sh;
   logic [7:0] alu_res;
   logic       alu_carry;
   logic [8:0] wide;
   logic [8:0] shr_wide;

   // Operand selection with WB -> EX forwarding of operand A
   always_comb begin
      op_a = EX_RegData1;
      if (WB_RegWrite && (WB_writeReg == EX_readReg1))
         op_a = WB_result;
      op_b = EX_ImmediateData;
      sh   = EX_ImmediateData[2:0];
   end

   // ALU / immediate load; carry comes from the 9th bit of a widened result
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      wide      = '0;
      shr_wide  = '0;
      if (EX_LoadImmediate) begin
         alu_res = op_b;
      end else begin
         case (alu_op_e'(EX_ALUop))
            OP_PASS: alu_res = op_a;
            OP_ADD: begin
               wide      = {1'b0, op_a} + {1'b0, op_b};
               alu_res   = wide[7:0];
               alu_carry = wide[8];
            end
            OP_SUB: begin
               wide      = {1'b0, op_a} - {1'b0, op_b};
               alu_res   = wide[7:0];
               alu_carry = wide[8];
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_NOT: alu_res = ~op_a;
            OP_SHL: begin
               // bit 8 of the widened shift is the last bit shifted out
               wide      = {1'b0, op_a} << sh;
               alu_res   = wide[7:0];
               alu_carry = wide[8];
            end
            OP_SHR: begin
               // a guard bit below the LSB catches the last bit shifted out
               shr_wide  = {op_a, 1'b0} >> sh;
               alu_res   = shr_wide[8:1];
               alu_carry = shr_wide[0];
            end
            OP_INC: begin
               alu_res   = op_a + 8'd1;
               alu_carry = (op_a == 8'hFF);
            end
            OP_DEC: begin
               alu_res   = op_a - 8'd1;
               alu_carry = (op_a == 8'h00);
            end
            default: begin
               alu_res   = '0;
               alu_carry = 1'b0;
            end
         endcase
      end
   end

   // EX/WB pipeline register; flags update only for register-writing instructions
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         WB_RegWrite <= 1'b0;
         WB_writeReg <= '0;
         WB_result   <= '0;
         WB_instr    <= '0;
         WB_zero     <= 1'b0;
         WB_carry    <= 1'b0;
      end else begin
         WB_RegWrite <= EX_RegWrite;
         WB_writeReg <= EX_writeReg;
         WB_result   <= alu_res;
         WB_instr    <= EX_instr;
         if (EX_RegWrite) begin
            WB_zero  <= (alu_res == 8'h00);
            WB_carry <= alu_carry;
         end
      end
   end

   // Register file commit from the WB stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 8; i++)
            rf[i] <= '0;
      end else if (WB_RegWrite) begin
         rf[WB_writeReg] <= WB_result;
      end
   end

   // ID read port with bypass of the value being written this cycle
   always_comb begin
      ID_RegData1 = rf[ID_readReg1];
      if (WB_RegWrite && (WB_writeReg == ID_readReg1))
         ID_RegData1 = WB_result;
   end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Execute and write-back back end of the 8-bit pipeline. It consumes the EX-side signals launched by the ID/EX pipeline register and performs the ALU operation or immediate load. It captures the result in an EX/WB register and commits it to an 8×8 register file. It also returns register data to the ID stage through a read port with write-back bypass, and forwards WB results into the next EX operation.

## Interface
Parameters:
- none (widths fixed: data 8, register address 3, ALUop 4)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- EX_ALUop  in  4  ALU operation for the instruction in EX
- EX_RegWrite  in  1  instruction in EX writes a register
- EX_LoadImmediate  in  1  result = EX_ImmediateData, ALUop ignored
- EX_RegData1  in  8  operand A as read in ID
- EX_readReg1  in  3  register address operand A was read from
- EX_writeReg  in  3  destination register
- EX_ImmediateData  in  8  operand B
- EX_instr  in  8  instruction byte, carried for debug
- ID_readReg1  in  3  ID-stage read address
- ID_RegData1  out  8  ID-stage read data (combinational, bypassed)
- WB_RegWrite  out  1  registered write enable
- WB_writeReg  out  3  registered destination
- WB_result  out  8  registered result
- WB_instr  out  8  registered instruction byte
- WB_zero  out  1  registered zero flag
- WB_carry  out  1  registered carry/borrow flag

## Operation
- Operand A = WB_result when WB_RegWrite=1 and WB_writeReg==EX_readReg1; otherwise EX_RegData1. Operand B = EX_ImmediateData.
- ALUop encoding; all results truncated to 8 bits:
  - 0000 pass A.
  - 0001 A+B, carry = bit 8.
  - 0010 A−B, carry = borrow (A<B unsigned).
  - 0011 AND. 0100 OR. 0101 XOR. 0110 NOT A.
  - 0111 A<<B[2:0], carry = last bit shifted out (0 if shift 0).
  - 1000 A>>B[2:0] logical, carry = last bit shifted out (0 if shift 0).
  - 1001 A+1, carry on 0xFF→0x00.
  - 1010 A−1, carry on 0x00→0xFF.
  - 1011–1111 result 0x00, carry 0.
  - Ops without a carry definition: carry = 0.
- EX_LoadImmediate=1 overrides ALUop: result = B, carry 0.
- Zero flag = (result == 0).
- EX/WB register captures result, EX_RegWrite, EX_writeReg and EX_instr every cycle (no stall input).
- WB_zero/WB_carry load only when EX_RegWrite=1; otherwise they hold.
- Register file: 8 entries × 8 bits, all addresses (including 0) writable. Written with WB_result at WB_writeReg on a rising edge when WB_RegWrite=1.
- ID_RegData1 = WB_result when WB_RegWrite=1 and WB_writeReg==ID_readReg1; otherwise the file entry.

## Timing
- Cycle N: EX inputs valid; ALU is combinational. The result is captured at the end of N.
- Cycle N+1: WB_* outputs show instruction N. EX forward and ID bypass both see WB_result. The register file is written at the end of N+1.
- Cycle N+2 onward: the file holds the value with no bypass needed.
- Latency: EX input to WB output is 1 cycle; EX input to architectural register is 2 edges.
- Back-to-back dependent instructions need no stall. A dependency two instructions back is served by the ID bypass.
- Simultaneous events:
  - WB write and ID read of the same address in one cycle: bypass returns the new value.
  - Forward match when WB_RegWrite=0: no forward.
- Reset (rst low, asynchronous, any cycle including mid-stream):
  - WB_RegWrite, WB_writeReg, WB_result, WB_instr, WB_zero and WB_carry go to 0.
  - All 8 file entries go to 0x00.
  - Any in-flight write is discarded.
- Release: the first capture happens on the first rising edge with rst high.

## Test plan
- Reset: drive rst low mid-operation -> all WB outputs 0 immediately. ID_RegData1 = 0x00 for addresses 0–7.
- Load/commit: LoadImmediate=1, imm 0x5A, writeReg 3, RegWrite=1 -> next cycle WB_result=0x5A and WB_zero=0. ID read r3 returns 0x5A that cycle (bypass) and afterwards (file).
- EX forward: r3 loaded 0x5A, next cycle ADD with readReg1=3, stale RegData1=0x00, imm 0x01 -> WB_result=0x5B.
- Carry/borrow: ADD 0xFF+0x01 -> result 0x00, zero=1, carry=1. SUB 0x10−0x20 -> result 0xF0, carry=1.
- Shifts/undefined: SHL 0x81 by 1 -> 0x02, carry 1. SHR 0x01 by 1 -> 0x00, carry 1, zero 1. ALUop 1100 -> 0x00, carry 0.
- Flag hold: ADD leaves zero=1, then RegWrite=0 instruction with nonzero result -> WB_zero stays 1, file unchanged.
